mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
- Sits directly downstream of the cpu top's memory port (mem_a/mem_dout/mem_wr/mem_din).
- Decodes each byte access to either the 128KB synchronous RAM or the memory-mapped I/O window (addr[17:16]==2'b11):
  - 0x30000: UART byte in/out.
  - 0x30004: cycle counter read / program stop.
- Owns the UART TX FIFO and the cycle counter.
- Produces the cpu's rdy signal, stalling it on TX-full writes and RX-empty reads.

Parameters:
TX_FIFO_DEPTH, 16, TX byte FIFO entries; power of two, >=2
RAM_ADDR_W, 17, RAM byte-address width

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; synchronous, active-high
sys_rdy_i  in  1  external run enable; cpu frozen when low
cpu_a_i  in  32  cpu byte address (bits 17:0 decoded)
cpu_dout_i  in  8  cpu write data
cpu_wr_i  in  1  1=write, 0=read
cpu_din_o  out  8  read data returned to cpu
cpu_rdy_o  out  1  drives cpu rdy_in
ram_en_o  out  1  RAM clock enable
ram_we_o  out  1  RAM write strobe
ram_a_o  out  RAM_ADDR_W  RAM address
ram_d_o  out  8  RAM write data
ram_q_i  in  8  RAM read data; valid one cycle after address, held while ram_en_o low
tx_data_o  out  8  UART TX byte
tx_valid_o  out  1  TX FIFO non-empty
tx_ready_i  in  1  UART accepts tx_data_o this cycle
rx_data_i  in  8  UART RX byte
rx_valid_i  in  1  RX byte available
rx_pop_o  out  1  consume rx_data_i
halt_o  out  1  sticky program-stop flag
clk_cnt_o  out  32  live cycle counter (debug)

Behaviour:
- Decode:
  - io = cpu_a_i[17:16]==2'b11.
  - port0 = io && cpu_a_i[2]==0.
  - port4 = io && cpu_a_i[2]==1.
  - Otherwise the access goes to RAM.
- Stall (combinational):
  - stall = (port0 && cpu_wr_i && cpu_dout_i!=0 && tx_full) || (port0 && !cpu_wr_i && !rx_valid_i) || (port4 && cpu_wr_i && tx_full).
  - cpu_rdy_o = sys_rdy_i && !stall.
  - An access "fires" only in cycles with cpu_rdy_o=1.
- RAM path:
  - ram_en_o = cpu_rdy_o.
  - ram_a_o = cpu_a_i[RAM_ADDR_W-1:0]; ram_d_o = cpu_dout_i.
  - ram_we_o = fire && cpu_wr_i && !io.
- Read latency:
  - A read firing in cycle t yields data on cpu_din_o in cycle t+1.
  - A 2-bit source register (RAM/RX/CNT/ZERO) and an 8-bit I/O data register update only on fire.
  - cpu_din_o muxes ram_q_i or the I/O register per the source register, so it is stable across stalls.
- RX read (port0, fire):
  - rx_pop_o=1 for exactly that cycle.
  - I/O register <= rx_data_i.
- TX write (port0, fire, data!=0): push cpu_dout_i. Data 0x00 is ignored and never stalls.
- Counter:
  - 32-bit; +1 every cycle while !halt_o, regardless of sys_rdy_i.
  - Wraps 0xFFFFFFFF->0.
  - Counter read at port4 with cpu_a_i[1:0]==0: snapshot the counter and return byte0.
  - Counter read with cpu_a_i[1:0]=1..3: return byte n of the existing snapshot (little-endian), so 4-byte reads are coherent.
- Port4 write (fire): halt_o<=1 (sticky until reset) and push 0x00 into the TX FIFO.
- TX FIFO:
  - Circular buffer, wrap-around pointers plus count.
  - Pop when tx_valid_o && tx_ready_i.
  - Push and pop in the same cycle while full is legal only because a full FIFO stalls the push; the push therefore never occurs when full.
  - Push+pop in the same cycle at non-full, non-empty: count unchanged.
- Reset (any cycle, including mid-stall):
  - FIFO empty; counter 0; snapshot 0; halt_o 0.
  - Source register ZERO, so cpu_din_o=0.
  - rx_pop_o, ram_we_o, tx_valid_o = 0.

Optional Feature:
- Macro: MEM_BRIDGE_OOB_TRAP_EN.
- Defined:
  - Non-io accesses with cpu_a_i[17]==1 are out-of-range.
  - Out-of-range writes are suppressed (ram_we_o=0).
  - Out-of-range reads return 0x00 via source ZERO.
  - Extra output oob_o (1 bit) is set sticky until reset.
- Undefined: no oob_o port; the address is truncated to RAM_ADDR_W and the access goes to RAM.

Decomposition:
- Package mem_io_pkg holds:
  - IO_BASE=18'h30000.
  - Port offsets 0x0 and 0x4.
  - Source enum {SRC_RAM, SRC_RX, SRC_CNT, SRC_ZERO}.
- One sub-module: byte_fifo (parameterised depth, push/pop/full/empty/count), instantiated for TX.

Test Plan:
- Write 0x55 to 0x00100, then read 0x00100 -> ram_we_o pulse with ram_a_o=0x100; next-cycle cpu_din_o=0x55; cpu_rdy_o stays 1.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready_i=1 -> tx_data_o sequence 0x41, 0x42 only.
- Fill 16 bytes with tx_ready_i=0, then write a 17th -> cpu_rdy_o=0 until tx_ready_i pulses once, then the 17th byte is pushed exactly once.
- Read 0x30000 with rx_valid_i=0 for 3 cycles, then rx_valid_i=1 with rx_data_i=0x7A -> cpu_rdy_o low for 3 cycles; a single rx_pop_o pulse; cpu_din_o=0x7A the next cycle.
- After 1000 cycles, read 0x30004..0x30007 with sys_rdy_i toggling between reads -> the 4 bytes assemble to the snapshot value taken at the 0x30004 read.
- Write to 0x30004 -> halt_o=1; TX emits 0x00; clk_cnt_o frozen; rst_in mid-stall clears all state and outputs.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared definitions for the CPU memory / I/O bridge.
// Holds the I/O window base, the port offsets, the read-source enum and a
// little-endian byte-select helper used for the counter snapshot.
package mem_io_pkg;

  localparam int unsigned IO_ADDR_W = 18;
  localparam logic [IO_ADDR_W-1:0] IO_BASE = 18'h30000;

  // Port offsets inside the I/O window; only bit 2 distinguishes them.
  localparam logic [2:0] PORT_UART = 3'h0;
  localparam logic [2:0] PORT_CNT  = 3'h4;

  // Where the byte on cpu_din_o comes from in the cycle after a read.
  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_RX   = 2'd1,
    SRC_CNT  = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  // Byte n of a 32-bit word, little-endian.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] n);
    return w[8*n +: 8];
  endfunction

endpackage

// File: rtl/mem_io_bridge_fifo.sv
// byte_fifo: circular byte FIFO with wrap-around pointers and an occupancy count.
// Ports: clk_i/rst_i (sync, active-high), push_i/data_i write side,
// pop_i/data_o read side (data_o shows the head entry), full_o, empty_o, count_o.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and count next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes CPU byte accesses to synchronous RAM or the I/O window
// (addr[17:16]==2'b11): 0x30000 UART byte in/out, 0x30004 cycle counter / stop.
// Ports: clk_in/rst_in (sync, active-high); sys_rdy_i run enable;
// cpu_a_i/cpu_dout_i/cpu_wr_i/cpu_din_o/cpu_rdy_o CPU side;
// ram_en_o/ram_we_o/ram_a_o/ram_d_o/ram_q_i RAM side;
// tx_data_o/tx_valid_o/tx_ready_i UART TX; rx_data_i/rx_valid_i/rx_pop_o UART RX;
// halt_o sticky stop flag; clk_cnt_o live cycle counter.
// Optional: define MEM_BRIDGE_OOB_TRAP_EN to trap non-I/O accesses with
// addr[17]==1 (writes dropped, reads return 0, sticky oob_o).
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned RAM_ADDR_W    = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sys_rdy_i,
  input  logic [31:0]           cpu_a_i,
  input  logic [7:0]            cpu_dout_i,
  input  logic                  cpu_wr_i,
  output logic [7:0]            cpu_din_o,
  output logic                  cpu_rdy_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [RAM_ADDR_W-1:0] ram_a_o,
  output logic [7:0]            ram_d_o,
  input  logic [7:0]            ram_q_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_pop_o,
  output logic                  halt_o,
  output logic [31:0]           clk_cnt_o
`ifdef MEM_BRIDGE_OOB_TRAP_EN
  ,
  output logic                  oob_o
`endif
);

  localparam int unsigned TX_CNT_W = $clog2(TX_FIFO_DEPTH + 1);

  logic       io, port0, port4, oob;
  logic       stall, fire;
  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0] tx_push_data;
  logic [TX_CNT_W-1:0] tx_count;

  src_e        src_q, src_d;
  logic [7:0]  io_q, io_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        halt_q, halt_d;

  // Address decode.
  assign io    = (cpu_a_i[17:16] == IO_BASE[17:16]);
  assign port0 = io && (cpu_a_i[2] == PORT_UART[2]);
  assign port4 = io && (cpu_a_i[2] == PORT_CNT[2]);

`ifdef MEM_BRIDGE_OOB_TRAP_EN
  logic oob_q;
  assign oob   = !io && cpu_a_i[17];
  assign oob_o = oob_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)             oob_q <= 1'b0;
    else if (fire && oob)   oob_q <= 1'b1;
  end
`else
  assign oob = 1'b0;
`endif

  // Stall on TX-full pushes (including the halt marker) and on RX-empty reads.
  assign stall = (port0 &&  cpu_wr_i && (cpu_dout_i != 8'h00) && tx_full)
              || (port0 && !cpu_wr_i && !rx_valid_i)
              || (port4 &&  cpu_wr_i && tx_full);
  assign cpu_rdy_o = sys_rdy_i && !stall;
  // Nothing fires during reset so strobes stay quiet in that cycle.
  assign fire = cpu_rdy_o && !rst_in;

  // RAM port.
  assign ram_en_o = cpu_rdy_o;
  assign ram_a_o  = cpu_a_i[RAM_ADDR_W-1:0];
  assign ram_d_o  = cpu_dout_i;
  assign ram_we_o = fire && cpu_wr_i && !io && !oob;

  // UART side.
  assign rx_pop_o     = fire && port0 && !cpu_wr_i;
  assign tx_push      = fire && cpu_wr_i && ((port0 && (cpu_dout_i != 8'h00)) || port4);
  assign tx_push_data = port4 ? 8'h00 : cpu_dout_i;
  assign tx_valid_o   = !tx_empty;
  assign tx_pop       = tx_valid_o && tx_ready_i;

  byte_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (tx_push),
    .data_i  (tx_push_data),
    .pop_i   (tx_pop),
    .data_o  (tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // Next state for read source, I/O data, counter, snapshot and halt.
  always_comb begin
    src_d  = src_q;
    io_d   = io_q;
    snap_d = snap_q;
    halt_d = halt_q;
    cnt_d  = halt_q ? cnt_q : cnt_q + 32'd1;
    if (fire) begin
      if (cpu_wr_i) begin
        if (port4) halt_d = 1'b1;
      end else if (port0) begin
        src_d = SRC_RX;
        io_d  = rx_data_i;
      end else if (port4) begin
        src_d = SRC_CNT;
        // Byte 0 takes a fresh snapshot; bytes 1..3 come from that snapshot.
        if (cpu_a_i[1:0] == 2'b00) begin
          snap_d = cnt_q;
          io_d   = cnt_q[7:0];
        end else begin
          io_d = byte_sel(snap_q, cpu_a_i[1:0]);
        end
      end else if (oob) begin
        src_d = SRC_ZERO;
      end else begin
        src_d = SRC_RAM;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q  <= SRC_ZERO;
      io_q   <= 8'h00;
      cnt_q  <= 32'd0;
      snap_q <= 32'd0;
      halt_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      io_q   <= io_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      halt_q <= halt_d;
    end
  end

  // Read data mux; RAM holds its output while disabled, so this is stall-stable.
  always_comb begin
    cpu_din_o = 8'h00;
    case (src_q)
      SRC_RAM:         cpu_din_o = ram_q_i;
      SRC_RX, SRC_CNT: cpu_din_o = io_q;
      default:         cpu_din_o = 8'h00;
    endcase
  end

  assign halt_o    = halt_q;
  assign clk_cnt_o = cnt_q;

  // Address bits and FIFO level not needed by this block.
  logic unused_bits;
  assign unused_bits = ^{cpu_a_i[31:18], cpu_a_i[3], tx_count};

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with queued expectations for TX bytes and reads.
module tb_mem_io_bridge;
  import mem_io_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sys_rdy_i;
  logic [31:0] cpu_a_i;
  logic [7:0]  cpu_dout_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_din_o;
  logic        cpu_rdy_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [16:0] ram_a_o;
  logic [7:0]  ram_d_o;
  logic [7:0]  ram_q_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_pop_o;
  logic        halt_o;
  logic [31:0] clk_cnt_o;
`ifdef MEM_BRIDGE_OOB_TRAP_EN
  logic        oob_o;
`endif

  mem_io_bridge dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .sys_rdy_i  (sys_rdy_i),
    .cpu_a_i    (cpu_a_i),
    .cpu_dout_i (cpu_dout_i),
    .cpu_wr_i   (cpu_wr_i),
    .cpu_din_o  (cpu_din_o),
    .cpu_rdy_o  (cpu_rdy_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_a_o    (ram_a_o),
    .ram_d_o    (ram_d_o),
    .ram_q_i    (ram_q_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_pop_o   (rx_pop_o),
    .halt_o     (halt_o),
    .clk_cnt_o  (clk_cnt_o)
`ifdef MEM_BRIDGE_OOB_TRAP_EN
    ,
    .oob_o      (oob_o)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: read-first, output held while disabled.
  logic [7:0] ram_mem [2**17];
  always @(posedge clk_in) begin
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_a_o] <= ram_d_o;
      ram_q_i <= ram_mem[ram_a_o];
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  tx_q [$];
  logic [7:0]  rd_q [$];
  int          rx_pop_cnt = 0;
  bit          halt_exp = 1'b0;
  logic [31:0] cyc_model = 32'd0;
  logic [31:0] snap;
  logic [31:0] frz;

  // Independent cycle-counter model.
  always @(posedge clk_in) begin
    if (rst_in)         cyc_model <= 32'd0;
    else if (!halt_exp) cyc_model <= cyc_model + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag);
    logic [7:0] e;
    e = rd_q.pop_front();
    check(tag, 32'(cpu_din_o), 32'(e));
  endtask

  // TX scoreboard: each accepted byte must match the oldest expected one.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid_o && tx_ready_i) begin
      check("tx_expected_present", 32'(tx_q.size() > 0), 32'd1);
      if (tx_q.size() > 0) check("tx_data", 32'(tx_data_o), 32'(tx_q.pop_front()));
    end
    if (rx_pop_o) rx_pop_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a_i = a; cpu_wr_i = wr; cpu_dout_i = d;
  endtask

  initial begin
    rst_in = 1'b1; sys_rdy_i = 1'b1; tx_ready_i = 1'b0;
    rx_data_i = 8'h00; rx_valid_i = 1'b0;
    drive(32'h0, 1'b0, 8'h00);

    // Reset state.
    step(2);
    check("rst_din", 32'(cpu_din_o), 32'h0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    check("rst_halt", 32'(halt_o), 32'h0);
    check("rst_cnt", clk_cnt_o, 32'h0);
    check("rst_rx_pop", 32'(rx_pop_o), 32'h0);
    check("rst_ram_we", 32'(ram_we_o), 32'h0);
    rst_in = 1'b0;
    step();
    check("cnt_first", clk_cnt_o, 32'd1);

    // RAM write then read.
    drive(32'h100, 1'b1, 8'h55);
    #1;
    check("ram_wr_we", 32'(ram_we_o), 32'h1);
    check("ram_wr_a", 32'(ram_a_o), 32'h100);
    check("ram_wr_d", 32'(ram_d_o), 32'h55);
    check("ram_wr_rdy", 32'(cpu_rdy_o), 32'h1);
    step();
    drive(32'h100, 1'b0, 8'h00);
    #1;
    check("ram_rd_we", 32'(ram_we_o), 32'h0);
    check("ram_rd_rdy", 32'(cpu_rdy_o), 32'h1);
    rd_q.push_back(8'h55);
    step();
    check_read("ram_rd_data");
    drive(32'h0, 1'b0, 8'h00);

    // TX with a zero byte in the middle.
    tx_ready_i = 1'b1;
    drive(32'h30000, 1'b1, 8'h41); tx_q.push_back(8'h41); step();
    drive(32'h30000, 1'b1, 8'h00);
    #1;
    check("tx_zero_rdy", 32'(cpu_rdy_o), 32'h1);
    step();
    drive(32'h30000, 1'b1, 8'h42); tx_q.push_back(8'h42); step();
    drive(32'h0, 1'b0, 8'h00);
    step(5);
    check("tx_drained1", 32'(tx_q.size()), 32'd0);

    // Fill the FIFO, then a 17th write stalls until one byte drains.
    tx_ready_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(32'h30000, 1'b1, 8'(i));
      #1;
      check("fill_rdy", 32'(cpu_rdy_o), 32'h1);
      tx_q.push_back(8'(i));
      step();
    end
    drive(32'h30000, 1'b1, 8'h11);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_stall", 32'(cpu_rdy_o), 32'h0);
      step();
    end
    tx_ready_i = 1'b1;
    #1;
    check("full_stall_pop", 32'(cpu_rdy_o), 32'h0);
    step();
    tx_ready_i = 1'b0;
    #1;
    check("full_release", 32'(cpu_rdy_o), 32'h1);
    tx_q.push_back(8'h11);
    step();
    drive(32'h0, 1'b0, 8'h00);
    tx_ready_i = 1'b1;
    step(20);
    check("tx_drained2", 32'(tx_q.size()), 32'd0);
    check("tx_empty", 32'(tx_valid_o), 32'h0);
    tx_ready_i = 1'b0;

    // RX read stalls while empty, then pops exactly once.
    rx_pop_cnt = 0;
    drive(32'h30000, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rx_stall", 32'(cpu_rdy_o), 32'h0);
      check("rx_no_pop", 32'(rx_pop_o), 32'h0);
      step();
    end
    rx_valid_i = 1'b1; rx_data_i = 8'h7A;
    #1;
    check("rx_rdy", 32'(cpu_rdy_o), 32'h1);
    check("rx_pop", 32'(rx_pop_o), 32'h1);
    rd_q.push_back(8'h7A);
    step();
    check_read("rx_data");
    rx_valid_i = 1'b0;
    drive(32'h0, 1'b0, 8'h00);
    step(3);
    check("rx_pop_once", 32'(rx_pop_cnt), 32'd1);

    // Coherent 4-byte counter read with stalls between bytes.
    step(1000);
    check("cnt_live", clk_cnt_o, cyc_model);
    for (int i = 0; i < 4; i++) begin
      sys_rdy_i = 1'b1;
      drive(32'h30004 + 32'(i), 1'b0, 8'h00);
      #1;
      if (i == 0) snap = cyc_model;
      check("cnt_rd_rdy", 32'(cpu_rdy_o), 32'h1);
      rd_q.push_back(byte_sel(snap, 2'(i)));
      step();
      check_read("cnt_byte");
      sys_rdy_i = 1'b0;
      #1;
      check("sys_rdy_low", 32'(cpu_rdy_o), 32'h0);
      step(2);
      check("cnt_byte_hold", 32'(cpu_din_o), 32'(byte_sel(snap, 2'(i))));
    end
    sys_rdy_i = 1'b1;
    drive(32'h0, 1'b0, 8'h00);

    // Program stop: halt, 0x00 on TX, counter frozen.
    tx_ready_i = 1'b1;
    drive(32'h30004, 1'b1, 8'hAB);
    #1;
    check("halt_rdy", 32'(cpu_rdy_o), 32'h1);
    tx_q.push_back(8'h00);
    step();
    halt_exp = 1'b1;
    drive(32'h0, 1'b0, 8'h00);
    check("halt_set", 32'(halt_o), 32'h1);
    frz = cyc_model;
    step(5);
    check("cnt_frozen", clk_cnt_o, frz);
    check("halt_tx_drained", 32'(tx_q.size()), 32'd0);
    check("halt_sticky", 32'(halt_o), 32'h1);

    // Reset in the middle of a TX-full stall.
    tx_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(32'h30000, 1'b1, 8'h20 + 8'(i));
      step();
    end
    drive(32'h30000, 1'b1, 8'h99);
    #1;
    check("pre_rst_stall", 32'(cpu_rdy_o), 32'h0);
    rst_in = 1'b1;
    halt_exp = 1'b0;
    tx_q.delete();
    #1;
    check("rst_mid_we", 32'(ram_we_o), 32'h0);
    step();
    check("rst_mid_halt", 32'(halt_o), 32'h0);
    check("rst_mid_cnt", clk_cnt_o, 32'h0);
    check("rst_mid_tx_valid", 32'(tx_valid_o), 32'h0);
    check("rst_mid_din", 32'(cpu_din_o), 32'h0);
    check("rst_mid_rdy", 32'(cpu_rdy_o), 32'h1);
    rst_in = 1'b0;
    drive(32'h0, 1'b0, 8'h00);
    step();
    check("post_rst_cnt", clk_cnt_o, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
